// File: rtl/risc_datapath.sv
// risc_datapath: 16-bit multicycle RISC datapath.
// PC, IR, 8x16 register file, add/sub ALU with NZC flags, 256x16 unified
// memory and an output register. All selects and enables come from an
// external controller, one step per clock.
module risc_datapath (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Buff_PC,
    input  logic        Branch,
    input  logic [1:0]  Jump,
    input  logic        MEMresource,
    input  logic        WE_MEM,
    input  logic        Buff_MEMIns,
    input  logic        ALUorNot,
    input  logic        LIorMOV,
    input  logic        WBresource,
    input  logic        RBresource,
    input  logic        oprandB,
    input  logic        LI,
    input  logic        PCplus1orWB,
    input  logic        WE_RF,
    input  logic        Buff_OutR,
    input  logic        ALUop,
    input  logic        Flag,
    input  logic        Buff_PSW,
    input  logic        TBorNot,
    input  logic        Tb_MEMWE,
    input  logic [7:0]  Tb_MEMAddr,
    input  logic [15:0] Tb_MEMData,
    output logic [15:0] OutR,
    output logic [2:0]  PSW_NZC,
    output logic [7:0]  InsM,
    output logic [1:0]  InsL,
    output logic [15:0] OutM,
    output logic [15:0] OutPC,
    output logic [15:0] OutNextPC
);

    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_imm;
    logic [15:0] r_aluout;
    logic [15:0] r_result;
    logic [15:0] r_mdr;
    logic [15:0] r_outr;
    logic [2:0]  r_psw;
    logic [15:0] r_rf [8];
    logic [15:0] r_mem [256];

    logic [2:0]  w_rd;
    logic [2:0]  w_rm;
    logic [2:0]  w_rn;
    logic [2:0]  w_rb_idx;
    logic [15:0] w_porta;
    logic [15:0] w_portb;
    logic [15:0] w_li_form;
    logic [15:0] w_opb;
    logic [15:0] w_opb_eff;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [2:0]  w_flags;
    logic [15:0] w_result_mux;
    logic [15:0] w_wb_data;
    logic [15:0] w_rf_wdata;
    logic [15:0] w_pc_plus1;
    logic [15:0] w_next_pc;
    logic [7:0]  w_mem_addr;
    logic        w_mem_we;
    logic [15:0] w_mem_wdata;
    logic [15:0] w_mem_rdata;
    logic        w_unused;

    assign w_rd = r_ir[10:8];
    assign w_rm = r_ir[7:5];
    assign w_rn = r_ir[4:2];

    assign w_rb_idx = RBresource ? w_rd : w_rn;
    assign w_porta  = r_rf[w_rm];
    assign w_portb  = r_rf[w_rb_idx];

    // LHI keeps the low byte of rd (read through port B) under the new high byte
    assign w_li_form = LI ? {r_ir[7:0], w_portb[7:0]} : {8'h00, r_ir[7:0]};

    // ALU: subtract is A + ~B + 1; Flag chains the previous carry for ADC/SBB
    assign w_opb     = oprandB ? {11'b0, r_ir[4:0]} : r_b;
    assign w_opb_eff = ALUop ? ~w_opb : w_opb;
    assign w_cin     = Flag ? r_psw[0] : ALUop;
    assign w_sum     = {1'b0, r_a} + {1'b0, w_opb_eff} + {16'b0, w_cin};
    assign w_flags   = {w_sum[15], (w_sum[15:0] == 16'h0000), w_sum[16]};

    assign w_result_mux = ALUorNot ? (LIorMOV ? r_a : r_imm) : r_aluout;
    assign w_wb_data    = WBresource ? r_mdr : r_result;
    assign w_pc_plus1   = r_pc + 16'd1;
    assign w_rf_wdata   = PCplus1orWB ? w_wb_data : w_pc_plus1;

    // Next-PC select; PC still holds the current instruction address here
    always_comb begin
        w_next_pc = w_pc_plus1;
        case (Jump)
            2'b00:   w_next_pc = Branch ? (w_pc_plus1 + {{8{r_ir[7]}}, r_ir[7:0]})
                                        : w_pc_plus1;
            2'b01:   w_next_pc = w_pc_plus1 + {{5{r_ir[10]}}, r_ir[10:0]};
            2'b10:   w_next_pc = w_porta;
            default: w_next_pc = w_portb;
        endcase
    end

    // Memory port is handed to the testbench pins while the CPU idles
    assign w_mem_addr  = TBorNot ? Tb_MEMAddr : (MEMresource ? r_aluout[7:0] : r_pc[7:0]);
    assign w_mem_we    = TBorNot ? Tb_MEMWE : WE_MEM;
    assign w_mem_wdata = TBorNot ? Tb_MEMData : r_b;
    assign w_mem_rdata = r_mem[w_mem_addr];

    // Memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
    end

    // Register file write
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 8; i++)
                r_rf[i] <= '0;
        end else if (WE_RF) begin
            r_rf[w_rd] <= w_rf_wdata;
        end
    end

    // Enabled architectural registers: PC, IR, OutR, PSW
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_outr <= '0;
            r_psw  <= '0;
        end else begin
            if (Buff_PC)     r_pc   <= w_next_pc;
            if (Buff_MEMIns) r_ir   <= w_mem_rdata;
            if (Buff_OutR)   r_outr <= w_porta;
            if (Buff_PSW)    r_psw  <= w_flags;
        end
    end

    // Free-running pipeline latches between multicycle steps
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_aluout <= '0;
            r_result <= '0;
            r_mdr    <= '0;
        end else begin
            r_a      <= w_porta;
            r_b      <= w_portb;
            r_imm    <= w_li_form;
            r_aluout <= w_sum[15:0];
            r_result <= w_result_mux;
            r_mdr    <= w_mem_rdata;
        end
    end

    // Only the low byte of ALUOut addresses memory
    assign w_unused = ^r_aluout[15:8];

    assign OutR      = r_outr;
    assign PSW_NZC   = r_psw;
    assign InsM      = r_ir[15:8];
    assign InsL      = r_ir[1:0];
    assign OutM      = w_mem_rdata;
    assign OutPC     = r_pc;
    assign OutNextPC = w_next_pc;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: the bench plays the controller, stepping
// a short program and checking architectural state against hand-derived values.
module tb_risc_datapath;

    logic        clk;
    logic        Rst;
    logic        Buff_PC, Branch;
    logic [1:0]  Jump;
    logic        MEMresource, WE_MEM, Buff_MEMIns, ALUorNot, LIorMOV;
    logic        WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF;
    logic        Buff_OutR, ALUop, Flag, Buff_PSW, TBorNot, Tb_MEMWE;
    logic [7:0]  Tb_MEMAddr;
    logic [15:0] Tb_MEMData;
    logic [15:0] OutR, OutM, OutPC, OutNextPC;
    logic [2:0]  PSW_NZC;
    logic [7:0]  InsM;
    logic [1:0]  InsL;

    int n_assert = 0;
    int n_fail   = 0;

    risc_datapath dut (
        .clk(clk), .Rst(Rst), .Buff_PC(Buff_PC), .Branch(Branch), .Jump(Jump),
        .MEMresource(MEMresource), .WE_MEM(WE_MEM), .Buff_MEMIns(Buff_MEMIns),
        .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .WBresource(WBresource),
        .RBresource(RBresource), .oprandB(oprandB), .LI(LI),
        .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF), .Buff_OutR(Buff_OutR),
        .ALUop(ALUop), .Flag(Flag), .Buff_PSW(Buff_PSW), .TBorNot(TBorNot),
        .Tb_MEMWE(Tb_MEMWE), .Tb_MEMAddr(Tb_MEMAddr), .Tb_MEMData(Tb_MEMData),
        .OutR(OutR), .PSW_NZC(PSW_NZC), .InsM(InsM), .InsL(InsL), .OutM(OutM),
        .OutPC(OutPC), .OutNextPC(OutNextPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        Buff_PC = 0; Branch = 0; Jump = 2'b00; MEMresource = 0; WE_MEM = 0;
        Buff_MEMIns = 0; ALUorNot = 0; LIorMOV = 0; WBresource = 0; RBresource = 0;
        oprandB = 0; LI = 0; PCplus1orWB = 0; WE_RF = 0; Buff_OutR = 0; ALUop = 0;
        Flag = 0; Buff_PSW = 0; TBorNot = 0; Tb_MEMWE = 0; Tb_MEMAddr = 8'h00;
        Tb_MEMData = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        idle();
        Buff_MEMIns = 1;
        tick();
    endtask

    // LLI (lhi=0) or LHI (lhi=1): decode, result, hold, write-back
    task automatic load_imm(input logic lhi);
        idle();
        LI = lhi; RBresource = lhi; ALUorNot = 1; LIorMOV = 0;
        tick();
        tick();
        tick();
        WE_RF = 1; PCplus1orWB = 1; WBresource = 0; Buff_PC = 1;
        tick();
    endtask

    task automatic out_r();
        idle();
        Buff_OutR = 1; Buff_PC = 1;
        tick();
    endtask

    logic [15:0] prog [10];
    logic [7:0]  addr;

    initial begin
        // LLI R0,0x0A; LLI R1,0x05; OutR R0; OutR R1; CMP R1,R0; LHI R0,0x12;
        // LDR R2,[R1-21]; OutR R0; OutR R2 (rd=R2); branch/jump word
        prog[0] = 16'h080A; prog[1] = 16'h0905; prog[2] = 16'h8000;
        prog[3] = 16'h8020; prog[4] = 16'h3020; prog[5] = 16'h1012;
        prog[6] = 16'h4235; prog[7] = 16'h8000; prog[8] = 16'h8240;
        prog[9] = 16'hC0FD;

        idle();
        Rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc",   OutPC, 16'h0000);
        check("reset_outr", OutR, 16'h0000);
        check("reset_psw",  {13'b0, PSW_NZC}, 16'h0000);
        check("reset_insm", {8'b0, InsM}, 16'h0000);
        Rst = 1;
        tick();

        // preload through the testbench port
        TBorNot = 1; Tb_MEMWE = 1;
        for (int i = 0; i < 10; i++) begin
            Tb_MEMAddr = 8'(i); Tb_MEMData = prog[i];
            tick();
        end
        Tb_MEMAddr = 8'hF0; Tb_MEMData = 16'h007C;
        tick();
        Tb_MEMWE = 0;
        for (int i = 0; i < 10; i++) begin
            Tb_MEMAddr = 8'(i);
            #1;
            check($sformatf("readback_%0d", i), OutM, prog[i]);
        end
        Tb_MEMAddr = 8'hF0;
        #1;
        check("readback_f0", OutM, 16'h007C);
        idle();

        fetch(); load_imm(1'b0);
        fetch(); load_imm(1'b0);
        check("pc_after_lli", OutPC, 16'h0002);

        fetch(); out_r();
        check("outr_r0", OutR, 16'h000A);
        fetch(); out_r();
        check("outr_r1", OutR, 16'h0005);
        check("pc_after_outr", OutPC, 16'h0004);

        // CMP: 5 - 10 = 0xFFFB -> N=1 Z=0 C=0 (borrow)
        fetch();
        check("insm_cmp", {8'b0, InsM}, 16'h0030);
        idle(); ALUop = 1;
        tick();
        Buff_PSW = 1; Buff_PC = 1;
        tick();
        check("cmp_psw", {13'b0, PSW_NZC}, 16'h0004);
        check("pc_after_cmp", OutPC, 16'h0005);

        fetch(); load_imm(1'b1);
        check("pc_after_lhi", OutPC, 16'h0006);

        // LDR R2: address = R1 - 21 = 0xFFF0 -> mem[0xF0]
        fetch();
        check("insm_ldr", {8'b0, InsM}, 16'h0042);
        check("insl_ldr", {14'b0, InsL}, 16'h0001);
        idle(); oprandB = 1; ALUop = 1;
        tick();
        tick();
        MEMresource = 1;
        #1;
        check("ldr_mem_read", OutM, 16'h007C);
        tick();
        WBresource = 1; PCplus1orWB = 1; WE_RF = 1; Buff_PC = 1;
        tick();
        check("pc_after_ldr", OutPC, 16'h0007);

        fetch(); out_r();
        check("outr_lhi_r0", OutR, 16'h120A);

        // OutR and write to the same register: OutR sees the old value
        fetch();
        idle(); Buff_OutR = 1; WE_RF = 1; PCplus1orWB = 0; Buff_PC = 1;
        tick();
        check("outr_same_reg_old", OutR, 16'h007C);
        check("pc_after_outr2", OutPC, 16'h0009);
        idle(); Buff_OutR = 1;
        tick();
        check("outr_same_reg_new", OutR, 16'h0009);

        // jump (imm11) and branch (imm8 = -3) from PC=9
        fetch();
        idle(); Jump = 2'b01;
        #1;
        check("next_pc_jump", OutNextPC, 16'h0107);
        Jump = 2'b00; Branch = 1;
        #1;
        check("next_pc_branch", OutNextPC, 16'h0007);
        Buff_PC = 1;
        tick();
        check("pc_after_branch", OutPC, 16'h0007);

        // JAL via R0 (0x120A), link PC+1 into R0
        fetch();
        idle(); Jump = 2'b10;
        #1;
        check("next_pc_jal", OutNextPC, 16'h120A);
        WE_RF = 1; PCplus1orWB = 0; Buff_PC = 1;
        tick();
        check("pc_after_jal", OutPC, 16'h120A);

        // JR via rd (R0 now holds the link 8)
        idle(); Jump = 2'b11; RBresource = 1;
        #1;
        check("next_pc_jr", OutNextPC, 16'h0008);
        Buff_PC = 1;
        tick();
        check("pc_after_jr", OutPC, 16'h0008);
        idle(); Buff_OutR = 1;
        tick();
        check("outr_link", OutR, 16'h0008);

        // asynchronous reset in the middle of an instruction
        fetch();
        idle(); ALUop = 1; Buff_PSW = 1;
        #3;
        Rst = 0;
        #1;
        check("midrst_pc",   OutPC, 16'h0000);
        check("midrst_outr", OutR, 16'h0000);
        check("midrst_psw",  {13'b0, PSW_NZC}, 16'h0000);
        idle();
        tick();
        Rst = 1;
        TBorNot = 1;
        for (int i = 0; i < 2; i++) begin
            addr = (i == 0) ? 8'h08 : 8'hF0;
            Tb_MEMAddr = addr;
            #1;
            check($sformatf("mem_kept_%02h", addr), OutM, (i == 0) ? 16'h8240 : 16'h007C);
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
